// File: rtl/reg_file_pkg.sv
// Shared types and constants for the integer register file.
// Default widths, register count, word/address typedefs, x0 index.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int NUM_REGS = 2 ** DEF_ADDR_WIDTH;
  localparam int ZERO_REG = 0;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, one write port.
// master = decode/writeback side, slave = register file.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output ReadRegister1,
    output ReadRegister2,
    output WriteRegister,
    output WriteData,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  ReadRegister1,
    input  ReadRegister2,
    input  WriteRegister,
    input  WriteData,
    output ReadData1,
    output ReadData2
  );

endinterface

// File: rtl/reg_file_read_port.sv
// Combinational read mux over the register view, x0 forced to zero.
// Ports: addr in, regs (packed view of all registers) in, data out.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                    addr,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  output logic [DATA_WIDTH-1:0]                    data
);

  assign data = (addr == ADDR_WIDTH'(ZERO_REG))
              ? '0
              : regs[addr];

endmodule

// File: rtl/reg_file.sv
// 32x32 integer register file, x0 hardwired to zero, no write bypass.
// Ports: CLK, RESET (sync, active-high), bus (reg_file_if.slave).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic CLK,
  input  logic RESET,
  reg_file_if.slave bus
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [1:NREGS-1];
  logic [NREGS-1:0][DATA_WIDTH-1:0] view;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.RegWrite &&
            bus.WriteRegister == ADDR_WIDTH'(i)) begin
          mem[i] <= bus.WriteData;
        end
      end
    end
  end

  // x0 has no storage; slot 0 of the view is a constant.
  always_comb begin
    view = '0;
    for (int i = 1; i < NREGS; i++) begin
      view[i] = mem[i];
    end
  end

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd1 (
    .addr (bus.ReadRegister1),
    .regs (view),
    .data (bus.ReadData1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd2 (
    .addr (bus.ReadRegister2),
    .regs (view),
    .data (bus.ReadData2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Drives the bus after each rising edge, checks combinational reads.
module tb_reg_file;
  import reg_file_pkg::*;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  reg_file_if bus ();

  reg_file dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input word_t got,
                     input word_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input reg_addr_t a1,
                    input reg_addr_t a2);
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    #1;
  endtask

  task automatic wr(input reg_addr_t a,
                    input word_t d);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = a;
    bus.WriteData     = d;
    tick();
    bus.RegWrite      = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET = 1'b1;
    bus.RegWrite      = 1'b0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    bus.WriteRegister = '0;
    bus.WriteData     = '0;

    tick();
    tick();
    RESET = 1'b0;

    rd(5'd0, 5'd1);
    chk("rst_r1_x0", bus.ReadData1, 32'h0);
    chk("rst_r2_x1", bus.ReadData2, 32'h0);
    rd(5'd31, 5'd0);
    chk("rst_r1_x31", bus.ReadData1, 32'h0);
    chk("rst_r2_x0", bus.ReadData2, 32'h0);
    rd(5'd1, 5'd31);
    chk("rst_r1_x1", bus.ReadData1, 32'h0);
    chk("rst_r2_x31", bus.ReadData2, 32'h0);

    wr(5'd0, 32'h12345678);
    rd(5'd0, 5'd0);
    chk("x0_r1", bus.ReadData1, 32'h0);
    chk("x0_r2", bus.ReadData2, 32'h0);

    wr(5'd1, 32'h11111111);
    wr(5'd2, 32'h22222222);
    wr(5'd3, 32'h33333333);
    rd(5'd1, 5'd2);
    chk("w_r1_x1", bus.ReadData1, 32'h11111111);
    chk("w_r2_x2", bus.ReadData2, 32'h22222222);
    rd(5'd3, 5'd1);
    chk("w_r1_x3", bus.ReadData1, 32'h33333333);
    chk("w_r2_x1", bus.ReadData2, 32'h11111111);

    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd5;
    bus.WriteData     = 32'hDEADBEEF;
    tick();
    rd(5'd5, 5'd5);
    chk("nowe_r1_x5", bus.ReadData1, 32'h0);
    chk("nowe_r2_x5", bus.ReadData2, 32'h0);

    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd4;
    bus.WriteData     = 32'hA5A5A5A5;
    rd(5'd4, 5'd4);
    chk("pre_r1_x4", bus.ReadData1, 32'h0);
    chk("pre_r2_x4", bus.ReadData2, 32'h0);
    tick();
    bus.RegWrite = 1'b0;
    chk("post_r1_x4", bus.ReadData1, 32'hA5A5A5A5);
    chk("post_r2_x4", bus.ReadData2, 32'hA5A5A5A5);

    wr(5'd31, 32'hCAFEF00D);
    rd(5'd31, 5'd3);
    chk("w_r1_x31", bus.ReadData1, 32'hCAFEF00D);
    chk("keep_r2_x3", bus.ReadData2, 32'h33333333);
    rd(5'd30, 5'd2);
    chk("keep_r1_x30", bus.ReadData1, 32'h0);
    chk("keep_r2_x2", bus.ReadData2, 32'h22222222);

    RESET             = 1'b1;
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd7;
    bus.WriteData     = 32'hFFFFFFFF;
    tick();
    RESET        = 1'b0;
    bus.RegWrite = 1'b0;
    rd(5'd1, 5'd2);
    chk("mrst_r1_x1", bus.ReadData1, 32'h0);
    chk("mrst_r2_x2", bus.ReadData2, 32'h0);
    rd(5'd3, 5'd7);
    chk("mrst_r1_x3", bus.ReadData1, 32'h0);
    chk("mrst_r2_x7", bus.ReadData2, 32'h0);
    rd(5'd4, 5'd31);
    chk("mrst_r1_x4", bus.ReadData1, 32'h0);
    chk("mrst_r2_x31", bus.ReadData2, 32'h0);

    wr(5'd7, 32'h0F0F1234);
    rd(5'd7, 5'd6);
    chk("after_r1_x7", bus.ReadData1, 32'h0F0F1234);
    chk("after_r2_x6", bus.ReadData2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
